ecc_apb_master: RTL and testbench

ECC_APB_MASTER -- requirements
Module: ecc_apb_master

---
 rtl/ecc_apb_pkg.sv | 20 ++
 rtl/ecc_apb_timeout_cnt.sv | 27 ++
 rtl/ecc_apb_master.sv | 105 ++++++++++
 tb/tb_ecc_apb_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC APB master: FSM state encoding, the ECC core
// register map and the address alignment helper.
package ecc_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [3:0] REG_SEL            = 4'h0;
  localparam logic [3:0] REG_DATA_IN        = 4'h4;
  localparam logic [3:0] REG_CODEWORD_WIDTH = 4'h8;
  localparam logic [3:0] REG_NOISE          = 4'hC;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ecc_apb_timeout_cnt.sv
// Counts consecutive ACCESS cycles without pready and flags expiry on the
// LIMIT-th one. Only instantiated when ECC_APB_MASTER_TIMEOUT_EN is defined.
module ecc_apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ecc_apb_master.sv
// Single-outstanding APB master: command in, IDLE/SETUP/ACCESS transfer, one-cycle
// response pulse out. Define ECC_APB_MASTER_TIMEOUT_EN to bound the pready wait.
module ecc_apb_master
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic                       pwrite,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       psel,
  output logic                       penable,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  apb_state_e state, state_nxt;

  logic accept;
  logic aligned;
  logic access_end;
  logic timeout;

  assign cmd_ready  = (state == ST_IDLE);
  assign psel       = (state != ST_IDLE);
  assign penable    = (state == ST_ACCESS);
  assign accept     = cmd_valid && cmd_ready;
  assign aligned    = is_word_aligned(cmd_addr[1:0]);
  assign access_end = (state == ST_ACCESS) && (pready || timeout);

`ifdef ECC_APB_MASTER_TIMEOUT_EN
  ecc_apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ST_ACCESS),
    .inc    ((state == ST_ACCESS) && !pready),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && aligned) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus-side latches hold through the transfer; response fields pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (accept && aligned) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
      if (accept && !aligned) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (access_end) begin
        rsp_valid <= 1'b1;
        rsp_err   <= pready ? pslverr : 1'b1;
        rsp_rdata <= (!pready || pwrite || pslverr) ? '0 : prdata;
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_master.sv
// Directed bench for ecc_apb_master with a response scoreboard and a simple
// wait-state APB slave. Honors ECC_APB_MASTER_TIMEOUT_EN when defined.
module tb_ecc_apb_master;
  import ecc_apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [19:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          n_vec  = 0;
  int          n_fail = 0;

  int          ws = 0;
  logic        hang = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] rdata_drv = '0;
  logic        err_drv = 1'b0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t sb[$];

  ecc_apb_master #(
    .AMBA_WORD      (32),
    .AMBA_ADDR_WIDTH(20),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  // Slave: raises pready after ws wait states in ACCESS unless hung.
  assign pready  = !hang && (acc_cnt >= ws);
  assign prdata  = rdata_drv;
  assign pslverr = err_drv;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("sb_expected_rsp", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        chk("sb_rsp_err", 64'(rsp_err), 64'(e.err));
        chk("sb_rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] regs[4];
    int          rsp_cnt;
    regs[0] = 20'(REG_SEL);
    regs[1] = 20'(REG_DATA_IN);
    regs[2] = 20'(REG_CODEWORD_WIDTH);
    regs[3] = 20'(REG_NOISE);

    // Reset state
    tick();
    tick();
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Zero-wait write to DATA_IN
    ws = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h4; cmd_wdata = 32'hDEADBEEF;
    sb.push_back('{1'b0, 32'h0});
    chk("wr_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_addr = 20'h0;
    chk("wr_setup_psel", 64'(psel), 64'd1);
    chk("wr_setup_penable", 64'(penable), 64'd0);
    chk("wr_paddr", 64'(paddr), 64'h4);
    chk("wr_pwdata", 64'(pwdata), 64'hDEADBEEF);
    chk("wr_pwrite", 64'(pwrite), 64'd1);
    chk("wr_setup_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("wr_access_psel", 64'(psel), 64'd1);
    chk("wr_access_penable", 64'(penable), 64'd1);
    chk("wr_access_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("wr_done_psel", 64'(psel), 64'd0);
    chk("wr_done_rsp", 64'(rsp_valid), 64'd1);
    tick();
    chk("wr_rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("wr_paddr_hold", 64'(paddr), 64'h4);

    // Read NOISE with two wait states
    ws = 2; rdata_drv = 32'h5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'hC;
    sb.push_back('{1'b0, 32'h5});
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_penable", 64'(penable), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_access_penable", 64'(penable), 64'd1);
      chk("rd_access_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    chk("rd_done_rsp", 64'(rsp_valid), 64'd1);
    chk("rd_done_psel", 64'(psel), 64'd0);
    tick();

    // Back-to-back writes to all four registers
    ws = 0; rsp_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_addr  = regs[i];
      cmd_wdata = 32'hA000_0000 + 32'(i);
      sb.push_back('{1'b0, 32'h0});
      chk("b2b_ready", 64'(cmd_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
        tick();
        if (rsp_valid) rsp_cnt++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_pulses", 64'(rsp_cnt), 64'd4);
    chk("b2b_last_paddr", 64'(paddr), 64'hC);
    chk("b2b_last_pwdata", 64'(pwdata), 64'hA000_0003);
    tick();

    // Misaligned read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h6;
    sb.push_back('{1'b1, 32'h0});
    tick();
    cmd_valid = 1'b0;
    chk("mis_psel", 64'(psel), 64'd0);
    chk("mis_rsp", 64'(rsp_valid), 64'd1);
    chk("mis_ready", 64'(cmd_ready), 64'd1);
    tick();
    chk("mis_psel_after", 64'(psel), 64'd0);

    // Slave error on read of CODEWORD_WIDTH
    err_drv = 1'b1; rdata_drv = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h8;
    sb.push_back('{1'b1, 32'h0});
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("slverr_rsp", 64'(rsp_valid), 64'd1);
    tick();
    err_drv = 1'b0;

    // Hung slave
    hang = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h0;
`ifdef ECC_APB_MASTER_TIMEOUT_EN
    sb.push_back('{1'b1, 32'h0});
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_access_penable", 64'(penable), 64'd1);
      chk("to_access_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    chk("to_abort_psel", 64'(psel), 64'd0);
    chk("to_abort_rsp", 64'(rsp_valid), 64'd1);
    tick();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
`else
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hang_psel", 64'(psel), 64'd1);
      chk("hang_rsp", 64'(rsp_valid), 64'd0);
    end
`endif

    // Reset in the middle of ACCESS
    chk("mid_penable", 64'(penable), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    rst = 1'b0; hang = 1'b0;
    tick();
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
